// File: rtl/led_strip_if.sv
// Bundle of the visualizer-facing inputs and the strip-facing outputs of led_strip_driver.
// The master side drives frame data; the slave side is the driver itself.
interface led_strip_if #(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12
);
    localparam int CW = $clog2(LEDS);

    logic [BIN_QTY-1:0][23:0]   rgb;
    logic [BIN_QTY-1:0][CW-1:0] LEDCounts;
    logic                       data_v;
    logic                       dout;
    logic                       busy;
    logic                       done;
    logic                       dropped;

    modport master (
        output rgb, LEDCounts, data_v,
        input  dout, busy, done, dropped
    );

    modport slave (
        input  rgb, LEDCounts, data_v,
        output dout, busy, done, dropped
    );
endinterface

// File: rtl/led_strip_driver.sv
// Expands one frame of per-bin colours/counts into LEDS pixels and drives a
// WS2812-style single-wire bitstream, followed by a low latch gap.
module led_strip_driver #(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12,
    parameter int TBIT    = 13,
    parameter int T0H     = 4,
    parameter int T1H     = 8,
    parameter int TRST    = 500
) (
    input  logic       clk,
    input  logic       rst,
    led_strip_if.slave bus
);
    localparam int CW   = $clog2(LEDS);
    localparam int PW   = $clog2(LEDS + 1);
    localparam int BW   = $clog2(BIN_QTY + 1);
    localparam int TMAX = (TBIT > TRST) ? TBIT : TRST;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TBIT_LAST = TW'(TBIT - 1);
    localparam logic [TW-1:0] TRST_LAST = TW'(TRST - 1);
    localparam logic [TW-1:0] T0H_W     = TW'(T0H);
    localparam logic [TW-1:0] T1H_W     = TW'(T1H);
    localparam logic [PW-1:0] PIX_LAST  = PW'(LEDS - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t                     state_q, state_d;
    logic [BIN_QTY-1:0][23:0]   rgb_q, rgb_d;
    logic [BIN_QTY-1:0][CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0]              bin_q, bin_d;
    logic [CW-1:0]              left_q, left_d;
    logic [PW-1:0]              pix_q, pix_d;
    logic [4:0]                 bit_q, bit_d;
    logic [TW-1:0]              tmr_q, tmr_d;
    logic                       dout_q, dout_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       dropped_q, dropped_d;

    logic [BW-1:0] eff_bin;
    logic [CW-1:0] eff_left;
    logic          found;
    logic [23:0]   colour;
    logic [23:0]   wire_word;
    logic          cur_bit;
    logic [TW-1:0] tmr_inc;

    // Resolve the bin feeding the current pixel, skipping exhausted or empty bins.
    always_comb begin
        eff_bin  = BW'(BIN_QTY);
        eff_left = '0;
        found    = 1'b0;
        colour   = '0;
        for (int i = 0; i < BIN_QTY; i++) begin
            if (!found) begin
                if (BW'(i) == bin_q && left_q != '0) begin
                    eff_bin  = BW'(i);
                    eff_left = left_q;
                    found    = 1'b1;
                    colour   = rgb_q[i];
                end else if (BW'(i) > bin_q && cnt_q[i] != '0) begin
                    eff_bin  = BW'(i);
                    eff_left = cnt_q[i];
                    found    = 1'b1;
                    colour   = rgb_q[i];
                end
            end
        end
        wire_word = {colour[15:8], colour[23:16], colour[7:0]};
        cur_bit   = wire_word[bit_q];
        tmr_inc   = tmr_q + TW'(1);
    end

    always_comb begin
        state_d   = state_q;
        rgb_d     = rgb_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        left_d    = left_q;
        pix_d     = pix_q;
        bit_d     = bit_q;
        tmr_d     = tmr_q;
        dout_d    = 1'b0;
        done_d    = 1'b0;
        dropped_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_v) begin
                    rgb_d   = bus.rgb;
                    cnt_d   = bus.LEDCounts;
                    bin_d   = '0;
                    left_d  = bus.LEDCounts[0];
                    pix_d   = '0;
                    bit_d   = 5'd23;
                    tmr_d   = '0;
                    dout_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                dropped_d = bus.data_v;
                if (tmr_q == TBIT_LAST) begin
                    tmr_d = '0;
                    if (bit_q == 5'd0) begin
                        bit_d  = 5'd23;
                        pix_d  = pix_q + PW'(1);
                        bin_d  = eff_bin;
                        left_d = found ? eff_left - CW'(1) : '0;
                        if (pix_q == PIX_LAST) begin
                            state_d = LATCH;
                        end else begin
                            dout_d = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q - 5'd1;
                        dout_d = 1'b1;
                    end
                end else begin
                    // dout is registered, so decide the level of the upcoming cycle.
                    tmr_d  = tmr_inc;
                    dout_d = tmr_inc < (cur_bit ? T1H_W : T0H_W);
                end
            end
            LATCH: begin
                dropped_d = bus.data_v;
                if (tmr_q == TRST_LAST) begin
                    tmr_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rgb_q     <= '0;
            cnt_q     <= '0;
            bin_q     <= '0;
            left_q    <= '0;
            pix_q     <= '0;
            bit_q     <= '0;
            tmr_q     <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rgb_q     <= rgb_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            left_q    <= left_d;
            pix_q     <= pix_d;
            bit_q     <= bit_d;
            tmr_q     <= tmr_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_led_strip_driver.sv
// Directed bench for led_strip_driver: decodes the dout waveform pixel by pixel
// and compares against pixels queued when each frame is launched.
module tb_led_strip_driver;
    localparam int LEDS    = 16;
    localparam int BIN_QTY = 12;
    localparam int TBIT    = 13;
    localparam int T0H     = 4;
    localparam int T1H     = 8;
    localparam int TRST    = 60;
    localparam int CW      = $clog2(LEDS);

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_strip_if #(.LEDS(LEDS), .BIN_QTY(BIN_QTY)) bus ();

    led_strip_driver #(
        .LEDS(LEDS), .BIN_QTY(BIN_QTY), .TBIT(TBIT),
        .T0H(T0H), .T1H(T1H), .TRST(TRST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [23:0] exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one accepted data_v and queues the pixels the frame should contain.
    task automatic applyStimulus(input logic [BIN_QTY-1:0][23:0] colours,
                                 input logic [BIN_QTY-1:0][CW-1:0] counts);
        int sent;
        sent = 0;
        bus.rgb       = colours;
        bus.LEDCounts = counts;
        bus.data_v    = 1'b1;
        for (int b = 0; b < BIN_QTY; b++) begin
            for (int k = 0; k < int'(counts[b]); k++) begin
                if (sent < LEDS) begin
                    exp_q.push_back({colours[b][15:8], colours[b][23:16], colours[b][7:0]});
                    sent++;
                end
            end
        end
        while (sent < LEDS) begin
            exp_q.push_back(24'h000000);
            sent++;
        end
        @(negedge clk);
        bus.data_v = 1'b0;
    endtask

    // Entered in the first cycle after the accepting edge; returns in the done cycle.
    task automatic checkFrame(input int inject_at);
        logic [23:0]     word;
        logic [23:0]     expw;
        logic [TBIT-1:0] smp;
        logic [TBIT-1:0] mask;
        int              h;
        int              c;
        logic            shape_ok;
        int              low_cnt;
        logic            busy_ok;
        c = 0;
        checkOutput("busy_start", {31'd0, bus.busy}, 32'd1);
        for (int p = 0; p < LEDS; p++) begin
            word     = '0;
            shape_ok = 1'b1;
            for (int b = 0; b < 24; b++) begin
                for (int j = 0; j < TBIT; j++) begin
                    if (c == inject_at) begin
                        bus.data_v = 1'b1;
                        bus.rgb    = ~bus.rgb;
                    end
                    if (inject_at >= 0 && c == inject_at + 1) begin
                        bus.data_v = 1'b0;
                        checkOutput("dropped", {31'd0, bus.dropped}, 32'd1);
                    end
                    smp[j] = bus.dout;
                    @(negedge clk);
                    c++;
                end
                h    = $countones(smp);
                mask = '0;
                for (int j = 0; j < h; j++) mask[j] = 1'b1;
                if (!((h == T0H || h == T1H) && smp === mask)) shape_ok = 1'b0;
                word = {word[22:0], (h == T1H)};
            end
            checkOutput($sformatf("pix%0d_shape", p), {31'd0, shape_ok}, 32'd1);
            checkOutput($sformatf("pix%0d_queue", p), exp_q.size(), LEDS - p);
            expw = (exp_q.size() > 0) ? exp_q.pop_front() : 24'h000000;
            checkOutput($sformatf("pix%0d", p), {8'd0, word}, {8'd0, expw});
        end
        low_cnt = 0;
        busy_ok = 1'b1;
        for (int j = 0; j < TRST; j++) begin
            if (bus.dout === 1'b0) low_cnt++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
        end
        checkOutput("latch_low", low_cnt, TRST);
        checkOutput("latch_busy", {31'd0, busy_ok}, 32'd1);
        checkOutput("done", {31'd0, bus.done}, 32'd1);
        checkOutput("busy_end", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [BIN_QTY-1:0][23:0]   col;
        logic [BIN_QTY-1:0][CW-1:0] cnt;

        bus.rgb       = '0;
        bus.LEDCounts = '0;
        bus.data_v    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_dout", {31'd0, bus.dout}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_dropped", {31'd0, bus.dropped}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] frame A: all counts zero");
        for (int b = 0; b < BIN_QTY; b++) col[b] = 24'($urandom);
        cnt = '0;
        applyStimulus(col, cnt);
        checkFrame(-1);
        @(negedge clk);

        $display("[TB] frame B: two red pixels");
        col = '0;
        col[0] = 24'hFF0000;
        cnt = '0;
        cnt[0] = CW'(2);
        applyStimulus(col, cnt);
        checkFrame(-1);
        @(negedge clk);

        $display("[TB] frame C: counts overflow the strip");
        for (int b = 0; b < BIN_QTY; b++) begin
            col[b] = {8'(16 * b + 1), 8'(8'h40 + b), 8'(8'h80 + 3 * b)};
            cnt[b] = CW'(2);
        end
        applyStimulus(col, cnt);
        checkFrame(-1);
        @(negedge clk);

        $display("[TB] frame D: sparse bins, data_v while busy");
        for (int b = 0; b < BIN_QTY; b++) col[b] = {8'(b), 8'(8'hA5 ^ b), 8'(8'h3C + b)};
        cnt = '0;
        cnt[1] = CW'(3);
        cnt[3] = CW'(4);
        cnt[4] = CW'(1);
        applyStimulus(col, cnt);
        checkFrame(99);
        @(negedge clk);

        $display("[TB] frame E: reset mid-frame");
        col = '1;
        cnt = '1;
        applyStimulus(col, cnt);
        repeat (1999) @(negedge clk);
        checkOutput("busy_mid", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_dout", {31'd0, bus.dout}, 32'd0);
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_done", {31'd0, bus.done}, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] frame F: clean frame after reset");
        for (int b = 0; b < BIN_QTY; b++) col[b] = 24'($urandom);
        cnt = '0;
        cnt[5]  = CW'(2);
        cnt[11] = CW'(5);
        applyStimulus(col, cnt);
        checkFrame(-1);

        $display("[TB] frame G: back-to-back start in done cycle");
        for (int b = 0; b < BIN_QTY; b++) begin
            col[b] = 24'($urandom);
            cnt[b] = CW'(1);
        end
        applyStimulus(col, cnt);
        checkOutput("b2b_dropped", {31'd0, bus.dropped}, 32'd0);
        checkFrame(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/led_strip_driver.md
# led_strip_driver

Serializes one frame of visualizer output into a single-wire WS2812-style LED bitstream. Sits directly downstream of the linear visualizer: consumes its per-bin colour (`rgb`), per-bin LED count (`LEDCounts`) and `data_v` strobe, then expands them into `LEDS` pixels and drives the strip data pin with bit-level pulse timing, followed by a latch (reset) gap.

## Interface
Parameters:
- `LEDS`, 50, pixels on the strip; frame length in pixels.
- `BIN_QTY`, 12, number of colour bins.
- `TBIT`, 13, clock cycles per bit.
- `T0H`, 4, high cycles for a 0 bit; must be less than `T1H`.
- `T1H`, 8, high cycles for a 1 bit; must be less than `TBIT`.
- `TRST`, 500, low cycles of the latch gap after the last bit.

Ports (reset is synchronous and active-high; one clock):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `rgb`  in  [BIN_QTY-1:0][23:0]  per-bin colour; [23:16]=R, [15:8]=G, [7:0]=B.
- `LEDCounts`  in  [BIN_QTY-1:0][$clog2(LEDS)-1:0]  pixels lit per bin.
- `data_v`  in  1  one-cycle strobe: `rgb`/`LEDCounts` valid this cycle.
- `dout`  out  1  registered strip data line.
- `busy`  out  1  frame in progress (SEND or LATCH).
- `done`  out  1  one-cycle pulse when a frame including its latch gap completes.
- `dropped`  out  1  one-cycle pulse when `data_v` arrives while busy.

## Operation
- States: IDLE, SEND, LATCH.
- IDLE: on `data_v`, capture all `rgb` and `LEDCounts` into internal registers, then go to SEND. Bin index = 0, pixels-left-in-bin = `LEDCounts[0]`, pixel counter = 0, bit index = 23.
- Pixel colour: while bin index < `BIN_QTY`, use `rgb[bin]` of the current bin. Bins with a count of 0 are skipped and contribute no pixels. Once all bins are exhausted, pad with 24'h000000 until `LEDS` pixels have been sent.
- Overflow: if the sum of the counts exceeds `LEDS`, transmission stops after exactly `LEDS` pixels. The remaining pixels of the current bin and all later bins are discarded.
- Wire order per pixel: G[7:0], R[7:0], B[7:0], each MSB first (24 bits).
- Bit encoding: `dout`=1 for `T1H` cycles if the bit is 1, or for `T0H` cycles if the bit is 0. `dout`=0 for the rest of `TBIT`.
- After bit 0 of pixel `LEDS`-1, go to LATCH. `dout`=0 for `TRST` cycles, then return to IDLE and pulse `done`.
- `data_v` while `busy`: ignored. Captured registers are unchanged, and `dropped` pulses on the next cycle.
- Counter widths: the bit-timer counts to `max(TBIT,TRST)`. The pixel counter is $clog2(LEDS+1) bits. The bin index is $clog2(BIN_QTY+1) bits.

## Timing
- Reset values: `dout`=0, `busy`=0, `done`=0, `dropped`=0, state IDLE.
- Reset asserted mid-frame: on the next edge all outputs return to their reset values and the frame is abandoned. No latch gap is emitted.
- `data_v` sampled at edge N:
  - `busy`=1 and `dout`=1 (first bit) from cycle N+1.
  - Bits occupy cycles N+1 … N+`LEDS`·24·`TBIT`.
  - The latch gap occupies the next `TRST` cycles.
- In cycle N+`LEDS`·24·`TBIT`+`TRST`+1: `busy`=0 and `done`=1. A `data_v` in this cycle is accepted (IDLE), does not raise `dropped`, and starts the next frame at the following cycle.
- Defaults give a frame of 15,600 + 500 = 16,100 cycles.
- Inputs are only sampled on the accepting `data_v` cycle. Changing them during a frame has no effect.

## Test plan
- All `LEDCounts`=0, any `rgb`, `data_v` at N:
  - 1200 bits, each high for exactly 4 cycles then low for 9.
  - `dout` low for 500 cycles.
  - `done` at N+16101 with `busy`=0.
- `LEDCounts[0]`=2, `rgb[0]`=24'hFF0000, all other counts 0:
  - Bits 0-47 decode to two pixels G=00 R=FF B=00 (1-bits high 8 cycles).
  - Bits 48-1199 are all 0-bits.
- Every `LEDCounts`=5 (sum 60) with distinct colours:
  - Decoded stream is 5 pixels each of bins 0-9 (exactly 50 pixels).
  - No bin-10/11 colour appears; frame length is still 16,100 cycles.
- `data_v` pulsed at N+100 during a frame with altered `rgb`:
  - `dropped`=1 at N+101.
  - Decoded frame equals the originally captured data.
- `rst` asserted at N+5000 mid-frame: `dout`=0, `busy`=0, `done`=0 next cycle. A new `data_v` after reset starts a clean frame with first `dout`=1 one cycle later.
- Back-to-back frames: `data_v` asserted in the `done` cycle is accepted with `dropped`=0, and the second frame's first bit starts the next cycle.
